fifo_mem: RTL and testbench



---
 rtl/fifo_mem.sv | 73 +++++++
 tb/tb_fifo_mem.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fifo_mem.sv
// fifo_mem: capture/log buffer. Words are written in arrival order at an
// internal write pointer until all entries are used, then full latches and
// further writes are dropped until reset. Any entry can be read back by
// absolute address through a one-cycle registered read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [$clog2(ADDR_SIZE)-1:0]  read_addr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          full,
  output logic [DATA_WIDTH-1:0]         data_out
);

  localparam int AW = $clog2(ADDR_SIZE);

  // Pointer-width constants so comparisons stay width-matched.
  localparam logic [AW:0] DEPTH    = (AW+1)'(ADDR_SIZE);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(ADDR_SIZE - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem [ADDR_SIZE];
  logic [AW:0]           wr_ptr;
  logic                  full_q;
  logic                  wr_acc;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  // A write is only taken while there is still a free entry; once full the
  // buffer is frozen so the captured log cannot be overwritten.
  assign wr_acc      = write_en && !full_q;
  // Only reachable when the depth is not a power of two.
  assign rd_in_range = ({1'b0, read_addr} < DEPTH);

  // Sequential capture: store the word, advance the pointer, latch full on
  // the write into the last entry. Reset wipes the contents and wins over a
  // simultaneous write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < ADDR_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
      wr_ptr              <= wr_ptr + PTR_ONE;
      if (wr_ptr == LAST_IDX) begin
        full_q <= 1'b1;
      end
    end
  end

  // ---- stage p1: registered read, sees contents before this edge's write
  // Read port: the old contents are returned on a same-address collision
  // because mem is sampled before the write in the block above lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_p1 <= '0;
    end else if (rd_in_range) begin
      rd_data_p1 <= mem[read_addr];
    end else begin
      rd_data_p1 <= '0;
    end
  end

  assign full     = full_q;
  assign data_out = rd_data_p1;

endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: scoreboard bench for fifo_mem (DATA_WIDTH=8, ADDR_SIZE=16).
// Each cycle the expected read result is computed from a behavioural model
// of the buffer before the edge and queued; it is popped and compared with
// data_out after the edge.
module tb_fifo_mem;

  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en;
  logic [3:0]    read_addr;
  logic [DW-1:0] data_in;
  logic          full;
  logic [DW-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mdl [N];
  int            mptr;
  logic          mfull;
  logic [DW-1:0] exp_q [$];

  fifo_mem #(.DATA_WIDTH(DW), .ADDR_SIZE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .read_addr (read_addr),
    .data_in   (data_in),
    .full      (full),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected read, update the model,
  // then compare after the edge.
  task automatic cyc(input logic r, input logic we, input logic [DW-1:0] din,
                     input logic [3:0] ra);
    logic [DW-1:0] e;
    rst       = r;
    write_en  = we;
    data_in   = din;
    read_addr = ra;
    e = (!r) ? '0 : mdl[ra];
    exp_q.push_back(e);
    if (!r) begin
      for (int i = 0; i < N; i++) mdl[i] = '0;
      mptr  = 0;
      mfull = 1'b0;
    end else if (we && !mfull) begin
      mdl[mptr] = din;
      mptr++;
      if (mptr == N) mfull = 1'b1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
    chk("full", {31'd0, full}, {31'd0, mfull});
  endtask

  initial begin
    rst = 1'b0; write_en = 1'b0; data_in = '0; read_addr = '0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    mptr = 0; mfull = 1'b0;

    // Reset, then every address reads zero.
    cyc(1'b0, 1'b0, 8'h00, 4'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_dout", {24'd0, data_out}, 32'd0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 4'(i));
      chk("rst_read", {24'd0, data_out}, 32'd0);
    end

    // Fill with 0xA0+i; full only after the 16th write.
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b1, 8'(8'hA0 + i), 4'd0);
      chk("fill_full", {31'd0, full}, (i == N-1) ? 32'd1 : 32'd0);
    end

    // Overflow attempts are ignored.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 8'hFF, 4'(i));
      chk("ovf_full", {31'd0, full}, 32'd1);
    end

    // Read sweep with one-cycle latency.
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 4'(i));
      chk("sweep", {24'd0, data_out}, 32'hA0 + 32'(i));
      chk("sweep_full", {31'd0, full}, 32'd1);
    end

    // Reset mid-fill after a partial capture.
    cyc(1'b0, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'(8'h11 + i), 4'd0);
    chk("part_full", {31'd0, full}, 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 4'd4);
    chk("part_a4", {24'd0, data_out}, 32'h15);
    cyc(1'b1, 1'b0, 8'h00, 4'd5);
    chk("part_a5", {24'd0, data_out}, 32'h00);

    // Reset with a simultaneous write: write discarded, contents cleared.
    cyc(1'b0, 1'b1, 8'h77, 4'd0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 4'(i));
      chk("clr_read", {24'd0, data_out}, 32'd0);
    end
    cyc(1'b1, 1'b1, 8'h99, 4'd0);
    cyc(1'b1, 1'b0, 8'h00, 4'd0);
    chk("restart_a0", {24'd0, data_out}, 32'h99);
    cyc(1'b1, 1'b0, 8'h00, 4'd1);
    chk("restart_a1", {24'd0, data_out}, 32'h00);

    // Read/write collision at address 3: old value first, new value next.
    cyc(1'b0, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h01 + i), 4'd0);
    cyc(1'b1, 1'b1, 8'h5A, 4'd3);
    chk("coll_old", {24'd0, data_out}, 32'h00);
    cyc(1'b1, 1'b0, 8'h00, 4'd3);
    chk("coll_new", {24'd0, data_out}, 32'h5A);
    cyc(1'b1, 1'b0, 8'h00, 4'd2);
    chk("coll_a2", {24'd0, data_out}, 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
